// File: rtl/cfg_reg_bank_pkg.sv
// Shared constants and types for the configuration register bank.
package cfg_reg_bank_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STAT_W = 48;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 16;

    // Address map anchors (word indices)
    localparam logic [WORD_W-1:0] ERR_WORD  = 8'h3F;
    localparam logic [WORD_W-1:0] STAT_BASE = 8'h40;

    // Transaction state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_ACK      = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;

    // Host request captured at the start of a transaction
    typedef struct packed {
        logic              rw;
        logic [WORD_W-1:0] word;
        logic [DATA_W-1:0] wdata;
    } cfg_req_t;

endpackage

// File: rtl/cfg_reg_bank_cs_sync.sv
// Multi-flop synchronizer bringing the host chip select into the clk domain.
module cs_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_raw,
    output logic cs
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= STAGES'({sync_q, cs_raw});
    end

    assign cs = sync_q[STAGES-1];

endmodule

// File: rtl/cfg_reg_bank.sv
// Host-accessible configuration register bank with status snapshots and sticky errors.
module cfg_reg_bank
    import cfg_reg_bank_pkg::*;
#(
    parameter int unsigned            NUM_RW   = 8,
    parameter int unsigned            NUM_STAT = 4,
    parameter logic [NUM_RW*32-1:0]   RW_RST   = '0,
    parameter int unsigned            TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_cs_n,
    input  logic                       cfg_rw,
    input  logic [31:0]                cfg_addr,
    input  logic [31:0]                cfg_wdata,
    output logic                       cfg_ack_n,
    output logic [31:0]                cfg_rdata,
    input  logic [NUM_STAT*48-1:0]     stat_in,
    output logic [NUM_RW*32-1:0]       rw_regs,
    output logic [NUM_RW-1:0]          wr_pulse,
    output logic [1:0]                 err_flags
);

    logic                             cs;
    logic                             cs_req;
    logic [2:0]                       state_q, state_d;
    cfg_req_t                         req_q, req_d;
    logic                             ack_n_q, ack_n_d;
    logic [DATA_W-1:0]                rdata_q, rdata_d;
    logic [NUM_RW*32-1:0]             regs_q, regs_d;
    logic [NUM_RW-1:0]                pulse_q, pulse_d;
    logic [1:0]                       err_q, err_d, err_set;
    logic                             err_clr;
    logic [NUM_STAT-1:0][STAT_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             unused_ok;

    assign cs_req = ~cfg_cs_n;

    cs_sync #(.STAGES(2)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_raw (cs_req),
        .cs     (cs)
    );

    // Next-state and datapath decode for one host transaction
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        ack_n_d  = ack_n_q;
        rdata_d  = rdata_q;
        regs_d   = regs_q;
        pulse_d  = '0;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        err_set  = '0;
        err_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ack_n_d = 1'b1;
                rdata_d = '0;
                cnt_d   = '0;
                if (cs && ack_n_q) begin
                    req_d.rw    = cfg_rw;
                    req_d.word  = cfg_addr[9:2];
                    req_d.wdata = cfg_wdata;
                    state_d     = cfg_rw ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                err_set[0] = 1'b1;
                for (int n = 0; n < NUM_RW; n++) begin
                    if (req_q.word == WORD_W'(n)) begin
                        regs_d[n*DATA_W +: DATA_W] = req_q.wdata;
                        pulse_d[n]                 = 1'b1;
                        err_set[0]                 = 1'b0;
                    end
                end
                state_d = ST_ACK;
            end
            ST_READ: begin
                rdata_d    = '0;
                err_set[0] = 1'b1;
                for (int n = 0; n < NUM_RW; n++) begin
                    if (req_q.word == WORD_W'(n)) begin
                        rdata_d    = regs_q[n*DATA_W +: DATA_W];
                        err_set[0] = 1'b0;
                    end
                end
                if (req_q.word == ERR_WORD) begin
                    rdata_d    = DATA_W'(err_q);
                    err_clr    = 1'b1;
                    err_set[0] = 1'b0;
                end
                // High half snapshots the full value so the low half read is coherent
                for (int n = 0; n < NUM_STAT; n++) begin
                    if (req_q.word == STAT_BASE + WORD_W'(2*n)) begin
                        rdata_d     = stat_in[n*STAT_W+16 +: DATA_W];
                        shadow_d[n] = stat_in[n*STAT_W +: STAT_W];
                        err_set[0]  = 1'b0;
                    end
                    if (req_q.word == STAT_BASE + WORD_W'(2*n+1)) begin
                        rdata_d    = {16'h0000, shadow_q[n][15:0]};
                        err_set[0] = 1'b0;
                    end
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!cs) begin
                    ack_n_d = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    err_set[1] = 1'b1;
                    ack_n_d    = 1'b1;
                    rdata_d    = '0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_REL;
                end else begin
                    ack_n_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!cs) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ack_n_d = 1'b1;
            end
        endcase

        // Clear-on-read loses to a flag raised in the same cycle
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            ack_n_q  <= 1'b1;
            rdata_q  <= '0;
            regs_q   <= RW_RST;
            pulse_q  <= '0;
            err_q    <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            ack_n_q  <= ack_n_d;
            rdata_q  <= rdata_d;
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg_ack_n = ack_n_q;
    assign cfg_rdata = rdata_q;
    assign rw_regs   = regs_q;
    assign wr_pulse  = pulse_q;
    assign err_flags = err_q;

    // Aliased address bits and the upper shadow bits are intentionally not decoded
    assign unused_ok = ^{cfg_addr[31:10], cfg_addr[1:0], shadow_q};

endmodule
